// File: rtl/vx_mq_fifo.sv
// vx_mq_fifo: NUM_QUEUES independent FIFOs sharing one storage array that is
// statically partitioned into DEPTH entries per queue. One push and one pop per
// cycle, each with its own queue select. Illegal operations are dropped and
// recorded in sticky per-queue error flags. A per-queue flush resets pointers.

// Elaboration-time parameter legality checks, kept out of the datapath module.
module vx_mq_fifo_param_chk #(
    parameter int NUM_QUEUES = 4,
    parameter int DEPTH      = 8,
    parameter int ALM_FULL   = DEPTH - 1,
    parameter int ALM_EMPTY  = 1
) ();
    if (NUM_QUEUES < 1) begin : g_nq_bad
        $error("vx_mq_fifo: NUM_QUEUES must be >= 1");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_bad
        $error("vx_mq_fifo: DEPTH must be a power of 2 and >= 2");
    end
    if ((ALM_FULL <= 0) || (ALM_FULL >= DEPTH)) begin : g_af_bad
        $error("vx_mq_fifo: ALM_FULL must satisfy 0 < ALM_FULL < DEPTH");
    end
    if ((ALM_EMPTY <= 0) || (ALM_EMPTY >= DEPTH)) begin : g_ae_bad
        $error("vx_mq_fifo: ALM_EMPTY must satisfy 0 < ALM_EMPTY < DEPTH");
    end
endmodule

module vx_mq_fifo #(
    parameter int DATAW      = 32,
    parameter int NUM_QUEUES = 4,
    parameter int DEPTH      = 8,
    parameter int ALM_FULL   = DEPTH - 1,
    parameter int ALM_EMPTY  = 1,
    parameter int QIDW       = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
    parameter int SIZEW      = $clog2(DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [QIDW-1:0]             push_qid,
    input  logic [DATAW-1:0]            data_in,
    input  logic                        pop,
    input  logic [QIDW-1:0]             pop_qid,
    output logic [DATAW-1:0]            data_out,
    input  logic [NUM_QUEUES-1:0]       flush,
    output logic [NUM_QUEUES-1:0]       empty,
    output logic [NUM_QUEUES-1:0]       full,
    output logic [NUM_QUEUES-1:0]       alm_empty,
    output logic [NUM_QUEUES-1:0]       alm_full,
    output logic [NUM_QUEUES*SIZEW-1:0] size,
    output logic [NUM_QUEUES-1:0]       err_overflow,
    output logic [NUM_QUEUES-1:0]       err_underflow
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int AW   = QIDW + PTRW;
    localparam int NENT = NUM_QUEUES * DEPTH;

    vx_mq_fifo_param_chk #(
        .NUM_QUEUES (NUM_QUEUES),
        .DEPTH      (DEPTH),
        .ALM_FULL   (ALM_FULL),
        .ALM_EMPTY  (ALM_EMPTY)
    ) u_param_chk ();

    // Per-queue state
    logic [PTRW-1:0]       wr_ptr_q [NUM_QUEUES];
    logic [PTRW-1:0]       wr_ptr_d [NUM_QUEUES];
    logic [PTRW-1:0]       rd_ptr_q [NUM_QUEUES];
    logic [PTRW-1:0]       rd_ptr_d [NUM_QUEUES];
    logic [SIZEW-1:0]      size_q   [NUM_QUEUES];
    logic [SIZEW-1:0]      size_d   [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] empty_q, empty_d;
    logic [NUM_QUEUES-1:0] full_q, full_d;
    logic [NUM_QUEUES-1:0] alm_empty_q, alm_empty_d;
    logic [NUM_QUEUES-1:0] alm_full_q, alm_full_d;
    logic [NUM_QUEUES-1:0] err_ovf_q, err_ovf_d;
    logic [NUM_QUEUES-1:0] err_unf_q, err_unf_d;

    // Shared storage (not reset)
    logic [DATAW-1:0]      mem_q [NENT];

    // Decoded per-cycle controls
    logic                  push_ok_s;
    logic                  pop_ok_s;
    logic                  pop_qid_ok_s;
    logic [NUM_QUEUES-1:0] push_hit_s;
    logic [NUM_QUEUES-1:0] pop_hit_s;
    logic [NUM_QUEUES-1:0] pop_legal_s;
    logic [NUM_QUEUES-1:0] push_acc_s;
    logic                  mem_we_s;
    logic [AW-1:0]         mem_waddr_s;
    logic [AW-1:0]         mem_raddr_s;

    // Queue selects outside the configured range never hit any queue.
    always_comb begin
        pop_qid_ok_s = ({1'b0, pop_qid} < (QIDW + 1)'(NUM_QUEUES));
        push_ok_s    = push & ({1'b0, push_qid} < (QIDW + 1)'(NUM_QUEUES));
        pop_ok_s     = pop & pop_qid_ok_s;
    end

    // Next-state for pointers, sizes, flags and the storage write port.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = {AW{1'b0}};
        push_hit_s  = {NUM_QUEUES{1'b0}};
        pop_hit_s   = {NUM_QUEUES{1'b0}};
        pop_legal_s = {NUM_QUEUES{1'b0}};
        push_acc_s  = {NUM_QUEUES{1'b0}};
        err_ovf_d   = err_ovf_q;
        err_unf_d   = err_unf_q;
        empty_d     = empty_q;
        full_d      = full_q;
        alm_empty_d = alm_empty_q;
        alm_full_d  = alm_full_q;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            wr_ptr_d[q] = wr_ptr_q[q];
            rd_ptr_d[q] = rd_ptr_q[q];
            size_d[q]   = size_q[q];

            push_hit_s[q]  = push_ok_s && (push_qid == QIDW'(q));
            pop_hit_s[q]   = pop_ok_s && (pop_qid == QIDW'(q));
            // Legality of a pop is judged on the occupancy at the start of the
            // cycle, so a same-cycle push never rescues a pop of an empty queue.
            pop_legal_s[q] = pop_hit_s[q] && !flush[q] && (size_q[q] != {SIZEW{1'b0}});
            // A full queue still accepts a push when it is popped in the same
            // cycle; a flushed queue always has room for the retained push.
            push_acc_s[q]  = push_hit_s[q] &&
                             (flush[q] || (size_q[q] != SIZEW'(DEPTH)) || pop_legal_s[q]);

            if (flush[q]) begin
                rd_ptr_d[q] = {PTRW{1'b0}};
                if (push_acc_s[q]) begin
                    wr_ptr_d[q] = PTRW'(1);
                    size_d[q]   = SIZEW'(1);
                end else begin
                    wr_ptr_d[q] = {PTRW{1'b0}};
                    size_d[q]   = {SIZEW{1'b0}};
                end
            end else begin
                wr_ptr_d[q] = wr_ptr_q[q] + (push_acc_s[q] ? PTRW'(1) : PTRW'(0));
                rd_ptr_d[q] = rd_ptr_q[q] + (pop_legal_s[q] ? PTRW'(1) : PTRW'(0));
                size_d[q]   = size_q[q] + (push_acc_s[q] ? SIZEW'(1) : SIZEW'(0))
                                        - (pop_legal_s[q] ? SIZEW'(1) : SIZEW'(0));
            end

            if (push_acc_s[q]) begin
                mem_we_s    = 1'b1;
                mem_waddr_s = {push_qid, (flush[q] ? {PTRW{1'b0}} : wr_ptr_q[q])};
            end else begin
                mem_we_s    = mem_we_s;
                mem_waddr_s = mem_waddr_s;
            end

            err_ovf_d[q] = err_ovf_q[q] | (push_hit_s[q] & ~push_acc_s[q]);
            // A pop of a queue being flushed is ignored without an error.
            err_unf_d[q] = err_unf_q[q] |
                           (pop_hit_s[q] & ~flush[q] & (size_q[q] == {SIZEW{1'b0}}));

            empty_d[q]     = (size_d[q] == {SIZEW{1'b0}});
            full_d[q]      = (size_d[q] == SIZEW'(DEPTH));
            alm_empty_d[q] = (size_d[q] <= SIZEW'(ALM_EMPTY));
            alm_full_d[q]  = (size_d[q] >= SIZEW'(ALM_FULL));
        end
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                wr_ptr_q[q] <= {PTRW{1'b0}};
                rd_ptr_q[q] <= {PTRW{1'b0}};
                size_q[q]   <= {SIZEW{1'b0}};
            end
            empty_q     <= {NUM_QUEUES{1'b1}};
            full_q      <= {NUM_QUEUES{1'b0}};
            alm_empty_q <= {NUM_QUEUES{1'b1}};
            alm_full_q  <= {NUM_QUEUES{1'b0}};
            err_ovf_q   <= {NUM_QUEUES{1'b0}};
            err_unf_q   <= {NUM_QUEUES{1'b0}};
        end else begin
            for (int q = 0; q < NUM_QUEUES; q++) begin
                wr_ptr_q[q] <= wr_ptr_d[q];
                rd_ptr_q[q] <= rd_ptr_d[q];
                size_q[q]   <= size_d[q];
            end
            empty_q     <= empty_d;
            full_q      <= full_d;
            alm_empty_q <= alm_empty_d;
            alm_full_q  <= alm_full_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= data_in;
        end
    end

    // Head-of-queue read for pop_qid; an empty or out-of-range queue reads 0.
    always_comb begin
        mem_raddr_s = {AW{1'b0}};
        data_out    = {DATAW{1'b0}};
        if (pop_qid_ok_s) begin
            mem_raddr_s = {pop_qid, rd_ptr_q[pop_qid]};
            if (size_q[pop_qid] != {SIZEW{1'b0}}) begin
                data_out = mem_q[mem_raddr_s];
            end else begin
                data_out = {DATAW{1'b0}};
            end
        end else begin
            data_out = {DATAW{1'b0}};
        end
    end

    // Flatten the registered per-queue occupancy onto the size bus.
    always_comb begin
        size = {(NUM_QUEUES * SIZEW){1'b0}};
        for (int q = 0; q < NUM_QUEUES; q++) begin
            size[q*SIZEW +: SIZEW] = size_q[q];
        end
    end

    assign empty         = empty_q;
    assign full          = full_q;
    assign alm_empty     = alm_empty_q;
    assign alm_full      = alm_full_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_vx_mq_fifo.sv
// Scoreboard bench for vx_mq_fifo: each stimulus cycle advances a queue-based
// reference model and enqueues the expected post-edge outputs; an independent
// monitor pops and compares them one cycle later.
module tb_vx_mq_fifo;

    localparam int NQ = 4;
    localparam int DP = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        push;
    logic [1:0]  push_qid;
    logic [31:0] data_in;
    logic        pop;
    logic [1:0]  pop_qid;
    logic [31:0] data_out;
    logic [3:0]  flush;
    logic [3:0]  empty, full, alm_empty, alm_full;
    logic [15:0] size;
    logic [3:0]  err_overflow, err_underflow;

    vx_mq_fifo dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .push          (push),
        .push_qid      (push_qid),
        .data_in       (data_in),
        .pop           (pop),
        .pop_qid       (pop_qid),
        .data_out      (data_out),
        .flush         (flush),
        .empty         (empty),
        .full          (full),
        .alm_empty     (alm_empty),
        .alm_full      (alm_full),
        .size          (size),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [3:0]  empty, full, ae, af, ovf, unf;
        logic [15:0] size;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mq[NQ][$];
    logic [3:0]  m_ovf = 4'd0;
    logic [3:0]  m_unf = 4'd0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] xp);
        if (act !== xp) begin
            miscompares++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, xp);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model, record expectation.
    task automatic step(input bit ps, input int pq, input logic [31:0] d,
                        input bit pp, input int rq, input logic [3:0] fl);
        int   pre[NQ];
        bit   pop_legal;
        exp_t e;
        @(posedge clk);
        #2;
        push = ps; push_qid = pq[1:0]; data_in = d;
        pop = pp; pop_qid = rq[1:0]; flush = fl;

        for (int q = 0; q < NQ; q++) pre[q] = mq[q].size();
        pop_legal = pp && !fl[rq] && (pre[rq] > 0);
        if (pp && !fl[rq] && pre[rq] == 0) m_unf[rq] = 1'b1;
        if (pop_legal) void'(mq[rq].pop_front());
        for (int q = 0; q < NQ; q++) if (fl[q]) mq[q].delete();
        if (ps) begin
            if (fl[pq] || pre[pq] < DP || (pop_legal && rq == pq)) mq[pq].push_back(d);
            else m_ovf[pq] = 1'b1;
        end

        e.dout = (mq[rq].size() > 0) ? mq[rq][0] : 32'd0;
        e.size = 16'd0;
        for (int q = 0; q < NQ; q++) begin
            e.empty[q] = (mq[q].size() == 0);
            e.full[q]  = (mq[q].size() == DP);
            e.ae[q]    = (mq[q].size() <= 1);
            e.af[q]    = (mq[q].size() >= DP - 1);
            e.size[q*4 +: 4] = 4'(mq[q].size());
        end
        e.ovf = m_ovf;
        e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    // Monitor: after every edge, compare DUT outputs with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("data_out",      data_out,             e.dout);
                chk("empty",         {28'd0, empty},       {28'd0, e.empty});
                chk("full",          {28'd0, full},        {28'd0, e.full});
                chk("alm_empty",     {28'd0, alm_empty},   {28'd0, e.ae});
                chk("alm_full",      {28'd0, alm_full},    {28'd0, e.af});
                chk("size",          {16'd0, size},        {16'd0, e.size});
                chk("err_overflow",  {28'd0, err_overflow},  {28'd0, e.ovf});
                chk("err_underflow", {28'd0, err_underflow}, {28'd0, e.unf});
            end
        end
    end

    initial begin
        int wait_cyc;
        reset_n = 1'b0;
        push = 1'b1; push_qid = 2'd2; data_in = 32'hDEAD_BEEF;
        pop = 1'b0; pop_qid = 2'd0; flush = 4'd0;
        repeat (3) @(posedge clk);
        #2;
        push = 1'b0;
        reset_n = 1'b1;

        // Reset state observed through idle cycles.
        step(0, 0, 32'd0, 0, 0, 4'd0);
        step(0, 0, 32'd0, 0, 2, 4'd0);

        // Fill / overflow / drain q2, three rounds to wrap the pointers.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DP; i++) step(1, 2, 32'h10 + 32'(i), 0, 2, 4'd0);
            step(1, 2, 32'h99, 0, 2, 4'd0);
            for (int i = 0; i < DP; i++) step(0, 0, 32'd0, 1, 2, 4'd0);
        end

        // q1 full: simultaneous push and pop keeps it full, new data lands last.
        for (int i = 0; i < DP; i++) step(1, 1, 32'h20 + 32'(i), 0, 1, 4'd0);
        step(1, 1, 32'hEE, 1, 1, 4'd0);
        for (int i = 0; i < DP; i++) step(0, 0, 32'd0, 1, 1, 4'd0);

        // q0 empty: push+pop in one cycle -> underflow, size 1.
        step(1, 0, 32'h55, 1, 0, 4'd0);
        step(0, 0, 32'd0, 0, 0, 4'd0);

        // Cross-queue: push q3 while popping q0.
        for (int i = 0; i < 20; i++) step(1, 3, 32'h300 + 32'(i), 1, 0, 4'd0);
        for (int i = 0; i < DP; i++) step(0, 0, 32'd0, 1, 3, 4'd0);

        // Flush with retained push, then flush with a simultaneous pop.
        for (int i = 0; i < 5; i++) step(1, 1, 32'h40 + 32'(i), 0, 1, 4'd0);
        step(1, 1, 32'hAB, 0, 1, 4'b0010);
        step(0, 0, 32'd0, 0, 1, 4'd0);
        step(0, 0, 32'd0, 1, 1, 4'b0010);
        step(0, 0, 32'd0, 0, 1, 4'd0);

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            logic [3:0] fl;
            for (int q = 0; q < NQ; q++) fl[q] = ($urandom_range(0, 63) == 0);
            step($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 99) < 55, int'($urandom_range(0, 3)), fl);
        end
        step(0, 0, 32'd0, 0, 0, 4'd0);

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
